// File: rtl/sync_signal_edge_pkg.sv
// Shared limits and helpers for the single-bit synchronizer / edge detector.
package sync_signal_edge_pkg;

  localparam int unsigned SYNC_STAGES_MIN = 2;
  localparam int unsigned SYNC_STAGES_MAX = 8;
  localparam int unsigned FILTER_LEN_MAX  = 255;
  localparam int unsigned FILTER_CNT_W    = 8;

  function automatic bit in_range(input int unsigned v, input int unsigned lo,
                                  input int unsigned hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/sync_glitch_filter.sv
// Glitch filter: the output level follows the input only after it has
// differed from the current output for FILTER_LEN consecutive cycles.
module sync_glitch_filter
  import sync_signal_edge_pkg::*;
#(
  parameter int unsigned FILTER_LEN  = 1,
  parameter logic        RESET_VALUE = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic level_i,
  output logic level_o
);

  localparam logic [FILTER_CNT_W-1:0] CNT_LAST = FILTER_CNT_W'(FILTER_LEN - 1);

  logic [FILTER_CNT_W-1:0] cnt_q, cnt_d;
  logic                    lvl_q, lvl_d;

  // Count consecutive disagreeing cycles; any agreement restarts the count.
  always_comb begin
    cnt_d = cnt_q;
    lvl_d = lvl_q;
    if (level_i == lvl_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      lvl_d = level_i;
    end else begin
      cnt_d = cnt_q + FILTER_CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      lvl_q <= RESET_VALUE;
    end else begin
      cnt_q <= cnt_d;
      lvl_q <= lvl_d;
    end
  end

  assign level_o = lvl_q;

endmodule

// File: rtl/sync_signal_edge.sv
// Brings one asynchronous pin into the clk domain and produces its level
// plus one-cycle rising/falling strobes.
module sync_signal_edge
  import sync_signal_edge_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned RESET_VALUE = 0,
  parameter int unsigned FILTER_LEN  = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic out,
  output logic rising,
  output logic falling
);

  localparam logic RST_BIT = 1'(RESET_VALUE);

  if (!in_range(SYNC_STAGES, SYNC_STAGES_MIN, SYNC_STAGES_MAX)) begin : g_bad_stages
    $fatal(1, "sync_signal_edge: SYNC_STAGES out of range");
  end
  if (!in_range(RESET_VALUE, 0, 1)) begin : g_bad_reset
    $fatal(1, "sync_signal_edge: RESET_VALUE must be 0 or 1");
  end
  if (!in_range(FILTER_LEN, 0, FILTER_LEN_MAX)) begin : g_bad_filter
    $fatal(1, "sync_signal_edge: FILTER_LEN out of range");
  end

  (* ASYNC_REG = "TRUE", SHREG_EXTRACT = "NO" *)
  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   synced;
  logic                   level;
  logic                   prev_q;

  always_comb sync_d = {sync_q[SYNC_STAGES-2:0], in};

  always_ff @(posedge clk) begin
    if (rst) sync_q <= {SYNC_STAGES{RST_BIT}};
    else     sync_q <= sync_d;
  end

  assign synced = sync_q[SYNC_STAGES-1];

  if (FILTER_LEN == 0) begin : g_no_filter
    assign level = synced;
  end else begin : g_filter
    sync_glitch_filter #(
      .FILTER_LEN (FILTER_LEN),
      .RESET_VALUE(RST_BIT)
    ) u_filter (
      .clk_i  (clk),
      .rst_i  (rst),
      .level_i(synced),
      .level_o(level)
    );
  end

  // History also resets, so leaving reset can never look like an edge.
  always_ff @(posedge clk) begin
    if (rst) prev_q <= RST_BIT;
    else     prev_q <= level;
  end

  assign out     = level;
  assign rising  = level & ~prev_q;
  assign falling = ~level & prev_q;

endmodule

// File: tb/tb_sync_signal_edge.sv
// Bench for sync_signal_edge: per-cycle vector table over three configurations
// plus a delay-line scoreboard on a toggling/random stream.
module tb_sync_signal_edge;

  logic clk;
  logic rst0, in0, out0, r0, f0;   // defaults
  logic rst1, in1, out1, r1, f1;   // FILTER_LEN=3
  logic rst2, in2, out2, r2, f2;   // SYNC_STAGES=4, RESET_VALUE=1

  int checks = 0;
  int errors = 0;

  sync_signal_edge u_dut0 (
    .clk(clk), .rst(rst0), .in(in0), .out(out0), .rising(r0), .falling(f0)
  );
  sync_signal_edge #(.SYNC_STAGES(2), .RESET_VALUE(0), .FILTER_LEN(3)) u_dut1 (
    .clk(clk), .rst(rst1), .in(in1), .out(out1), .rising(r1), .falling(f1)
  );
  sync_signal_edge #(.SYNC_STAGES(4), .RESET_VALUE(1), .FILTER_LEN(0)) u_dut2 (
    .clk(clk), .rst(rst2), .in(in2), .out(out2), .rising(r2), .falling(f2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int   dut;
    logic rst;
    logic din;
    logic out;
    logic rise;
    logic fall;
  } vec_t;

  vec_t tbl[$];
  logic exp_q[$];

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %b want %b", name, act, exp);
    end
  endtask

  task automatic add(input int d, input logic r, input logic i, input logic o,
                     input logic ri, input logic fa, input int n = 1);
    for (int k = 0; k < n; k++) tbl.push_back('{d, r, i, o, ri, fa});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic o, ri, fa, v, prev_exp, exp;

    rst0 = 1'b1; in0 = 1'b1;
    rst1 = 1'b1; in1 = 1'b0;
    rst2 = 1'b1; in2 = 1'b0;

    // dut0: reset with in=1, release, first rising on the 2nd edge
    add(0, 1, 1, 0, 0, 0, 2);
    add(0, 0, 1, 0, 0, 0);
    add(0, 0, 1, 1, 1, 0);
    add(0, 0, 1, 1, 0, 0, 3);
    // step 1->0 then 0->1
    add(0, 0, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 4);
    add(0, 0, 1, 0, 0, 0);
    add(0, 0, 1, 1, 1, 0);
    add(0, 0, 1, 1, 0, 0, 3);
    // reset while out=1: drops to 0 with no falling pulse, then re-rises
    add(0, 1, 1, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0);
    add(0, 0, 1, 1, 1, 0);
    add(0, 0, 1, 1, 0, 0);
    // bring out back to 0
    add(0, 0, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 2);
    // reset lands on the edge where the rising pulse would have appeared
    add(0, 0, 1, 0, 0, 0);
    add(0, 1, 1, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0);
    add(0, 0, 1, 1, 1, 0);
    add(0, 0, 1, 1, 0, 0);
    add(0, 0, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 3);

    // dut1 (filter 3): reset, 2-cycle glitch is swallowed
    add(1, 1, 0, 0, 0, 0, 2);
    add(1, 0, 0, 0, 0, 0, 2);
    add(1, 0, 1, 0, 0, 0, 2);
    add(1, 0, 0, 0, 0, 0, 5);
    // 5-cycle pulse: rising after 2+3 edges, falling 5 edges after the drop
    add(1, 0, 1, 0, 0, 0, 4);
    add(1, 0, 1, 1, 1, 0);
    add(1, 0, 0, 1, 0, 0, 4);
    add(1, 0, 0, 0, 0, 1);
    add(1, 0, 0, 0, 0, 0, 2);

    // dut2 (4 stages, reset value 1): reset with in=0, falling after 4 edges
    add(2, 1, 0, 1, 0, 0, 2);
    add(2, 0, 0, 1, 0, 0, 3);
    add(2, 0, 0, 0, 0, 1);
    add(2, 0, 0, 0, 0, 0, 2);
    add(2, 0, 1, 0, 0, 0, 3);
    add(2, 0, 1, 1, 1, 0);
    add(2, 0, 1, 1, 0, 0, 2);

    foreach (tbl[i]) begin
      case (tbl[i].dut)
        0:       begin rst0 = tbl[i].rst; in0 = tbl[i].din; end
        1:       begin rst1 = tbl[i].rst; in1 = tbl[i].din; end
        default: begin rst2 = tbl[i].rst; in2 = tbl[i].din; end
      endcase
      tick();
      case (tbl[i].dut)
        0:       begin o = out0; ri = r0; fa = f0; end
        1:       begin o = out1; ri = r1; fa = f1; end
        default: begin o = out2; ri = r2; fa = f2; end
      endcase
      chk($sformatf("row%0d_dut%0d_out", i, tbl[i].dut), o, tbl[i].out);
      chk($sformatf("row%0d_dut%0d_rising", i, tbl[i].dut), ri, tbl[i].rise);
      chk($sformatf("row%0d_dut%0d_falling", i, tbl[i].dut), fa, tbl[i].fall);
    end

    // dut0 stream: 8 toggles then random; expected out is in delayed by 2 edges
    exp_q.push_back(1'b0);
    prev_exp = 1'b0;
    for (int n = 0; n < 48; n++) begin
      v = (n < 8) ? ((n % 2) == 0) : 1'($urandom_range(0, 1));
      in0 = v;
      exp_q.push_back(v);
      tick();
      exp = exp_q.pop_front();
      chk($sformatf("stream%0d_out", n), out0, exp);
      chk($sformatf("stream%0d_rising", n), r0, exp & ~prev_exp);
      chk($sformatf("stream%0d_falling", n), f0, ~exp & prev_exp);
      chk($sformatf("stream%0d_exclusive", n), r0 & f0, 1'b0);
      prev_exp = exp;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
